// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants and types for the load/store unit.
//   funct3 access-size codes, FSM state type, error cause codes.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // state  | meaning
  // IDLE   | accept a new MEM-stage request
  // RMW_WR | write back the merged word of a sub-word store
  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte/halfword lane logic.
//   i_funct3     access size/sign
//   i_offset     byte offset within the word (addr[1:0])
//   i_word       word read from data memory
//   i_wdata      right-aligned store data
//   o_load_data  extracted and extended load value
//   o_merge_data word to write: i_word with the store lane replaced
//                (i_wdata unchanged for word stores)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[{i_offset, 3'b000} +: 8];
    w_half = i_word[{i_offset[1], 4'b0000} +: 16];

    o_load_data = i_word;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_data = {24'h000000, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_data = {16'h0000, w_half};
      default: o_load_data = i_word;
    endcase

    o_merge_data = i_word;
    case (i_funct3)
      F3_B:    o_merge_data[{i_offset, 3'b000} +: 8]     = i_wdata[7:0];
      F3_H:    o_merge_data[{i_offset[1], 4'b0000} +: 16] = i_wdata[15:0];
      default: o_merge_data = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: MEM-stage load/store unit in front of a word-only data memory.
//   clk, rst                 clock, synchronous active-high reset
//   valid_i, mem_read_i,
//   mem_write_i, funct3_i,
//   addr_i, wdata_i, rd_i    MEM-stage request
//   stall_o                  hold upstream (first cycle of a sub-word store)
//   dmem_*                   word memory port (combinational read)
//   wb_valid_o/rd_o/data_o   registered load result
//   err_o, err_cause_o       registered one-cycle error pulse and cause
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_i,
  output logic        stall_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic        dmem_we_o,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        err_o,
  output logic [1:0]  err_cause_o
);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_rmw_addr;
  logic [31:0] r_rmw_data;

  logic        w_req;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_load_en;
  logic        w_rmw_latch;
  logic        w_err;
  logic [1:0]  w_cause;
  logic [31:0] w_load_data;
  logic [31:0] w_merge_data;

  lsu_align u_align (
    .i_funct3     (funct3_i),
    .i_offset     (addr_i[1:0]),
    .i_word       (dmem_rdata_i),
    .i_wdata      (wdata_i),
    .o_load_data  (w_load_data),
    .o_merge_data (w_merge_data)
  );

  assign w_req = valid_i & (mem_read_i | mem_write_i);

  // 011/110/111 are not loads; only B/H/W exist for stores.
  assign w_illegal = (mem_read_i & mem_write_i)
                   | (mem_read_i  & ((funct3_i == 3'b011) | (funct3_i[2:1] == 2'b11)))
                   | (mem_write_i & (funct3_i[2] | (funct3_i[1:0] == 2'b11)));

  // funct3[1:0] gives the size for both signed and unsigned variants.
  assign w_misalign = ((funct3_i[1:0] == 2'b01) & addr_i[0])
                    | ((funct3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    stall_o      = 1'b0;
    dmem_addr_o  = {addr_i[31:2], 2'b00};
    dmem_wdata_o = w_merge_data;
    dmem_we_o    = 1'b0;
    w_load_en    = 1'b0;
    w_rmw_latch  = 1'b0;
    w_err        = 1'b0;
    w_cause      = ERR_NONE;

    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_illegal) begin
            w_err   = 1'b1;
            w_cause = ERR_ILLEGAL;
          end else if (w_misalign) begin
            w_err   = 1'b1;
            w_cause = ERR_MISALIGN;
          end else if (mem_read_i) begin
            w_load_en = 1'b1;
          end else if (funct3_i == F3_W) begin
            dmem_we_o = 1'b1;
          end else begin
            stall_o      = 1'b1;
            w_rmw_latch  = 1'b1;
            w_next_state = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        // The request still held upstream belongs to this store; ignore it.
        dmem_addr_o  = r_rmw_addr;
        dmem_wdata_o = r_rmw_data;
        dmem_we_o    = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase

    if (rst) begin
      w_next_state = IDLE;
      stall_o      = 1'b0;
      dmem_addr_o  = 32'h0;
      dmem_wdata_o = 32'h0;
      dmem_we_o    = 1'b0;
      w_load_en    = 1'b0;
      w_rmw_latch  = 1'b0;
      w_err        = 1'b0;
      w_cause      = ERR_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rmw_addr  <= 32'h0;
      r_rmw_data  <= 32'h0;
      wb_valid_o  <= 1'b0;
      wb_rd_o     <= 5'd0;
      wb_data_o   <= 32'h0;
      err_o       <= 1'b0;
      err_cause_o <= ERR_NONE;
    end else begin
      if (w_rmw_latch) begin
        r_rmw_addr <= {addr_i[31:2], 2'b00};
        r_rmw_data <= w_merge_data;
      end
      wb_valid_o <= w_load_en;
      if (w_load_en) begin
        wb_rd_o   <= rd_i;
        wb_data_o <= w_load_data;
      end
      err_o       <= w_err;
      err_cause_o <= w_cause;
    end
  end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic [4:0]  rd_i;
  logic        stall_o, dmem_we_o, wb_valid_o, err_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i, wb_data_o;
  logic [4:0]  wb_rd_o;
  logic [1:0]  err_cause_o;

  int n_checks = 0;
  int n_errors = 0;

  // Word memory seen by the DUT, and an independent byte-level reference.
  logic [31:0] mem_w [0:63];
  logic [7:0]  ref_b [0:255];

  always #5 clk = ~clk;

  assign dmem_rdata_i = mem_w[dmem_addr_o[7:2]];

  always @(posedge clk) if (dmem_we_o) mem_w[dmem_addr_o[7:2]] <= dmem_wdata_o;

  lsu dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .funct3_i(funct3_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rd_i(rd_i), .stall_o(stall_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_we_o(dmem_we_o), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .err_o(err_o), .err_cause_o(err_cause_o)
  );

  typedef struct {
    logic        r, w;
    logic [2:0]  f3;
    logic [31:0] a, wd;
    logic        e_err;
    logic [1:0]  e_cause;
    logic        e_valid;
    logic [31:0] e_data;
  } vec_t;

  vec_t vt [0:15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic preset(input logic [31:0] a, input logic [31:0] w);
    mem_w[a[7:2]] <= w;
    for (int i = 0; i < 4; i++) ref_b[{a[7:2], 2'b00} + i] = w[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < 4; i++) v = v | ({24'h0, ref_b[{a[7:2], 2'b00} + i]} << (8*i));
    return v;
  endfunction

  // One request, including the RMW cycle for sub-word stores; returns
  // the registered outputs seen after the request cycle.
  task automatic op(input logic v, r, w, input logic [2:0] f3,
                    input logic [31:0] a, wd, input logic [4:0] rd,
                    output logic o_err, output logic [1:0] o_cause,
                    output logic o_valid, output logic [31:0] o_data);
    bit act, ill, mis, is_ld, is_sw, is_rmw;
    int sz, ba;
    logic [31:0] ldv, mw;
    act = v && (r || w);
    ill = act && ((r && w) || (r && (f3 == 3 || f3 == 6 || f3 == 7)) || (w && f3 > 2));
    sz  = 1 << f3[1:0];
    mis = act && !ill && ((a % sz) != 0);
    is_ld  = act && !ill && !mis && r;
    is_sw  = act && !ill && !mis && w && sz == 4;
    is_rmw = act && !ill && !mis && w && sz < 4;
    ba = int'(a[7:0]);
    ldv = 32'h0;
    if (is_ld) begin
      for (int i = 0; i < sz; i++) ldv = ldv | ({24'h0, ref_b[ba + i]} << (8*i));
      if (!f3[2] && sz < 4 && ldv[8*sz-1]) ldv = ldv | (32'hFFFFFFFF << (8*sz));
    end

    @(negedge clk);
    valid_i = v; mem_read_i = r; mem_write_i = w; funct3_i = f3;
    addr_i = a; wdata_i = wd; rd_i = rd;
    #1;
    chk("stall", {31'h0, stall_o}, {31'h0, is_rmw});
    chk("we", {31'h0, dmem_we_o}, {31'h0, is_sw});
    if (is_ld || is_sw || is_rmw) chk("dmem_addr", dmem_addr_o, a & 32'hFFFFFFFC);
    if (is_sw) chk("sw_wdata", dmem_wdata_o, wd);
    @(posedge clk); #1;
    o_err = err_o; o_cause = err_cause_o; o_valid = wb_valid_o; o_data = wb_data_o;
    chk("wb_valid", {31'h0, wb_valid_o}, {31'h0, is_ld});
    chk("err", {31'h0, err_o}, {31'h0, ill || mis});
    if (ill)  chk("cause", {30'h0, err_cause_o}, 32'h2);
    if (mis)  chk("cause", {30'h0, err_cause_o}, 32'h1);
    if (is_ld) begin
      chk("wb_data", wb_data_o, ldv);
      chk("wb_rd", {27'h0, wb_rd_o}, {27'h0, rd});
    end
    if (is_sw || is_rmw)
      for (int i = 0; i < sz; i++) ref_b[ba + i] = wd[8*i +: 8];
    if (is_rmw) begin
      mw = ref_word(a);
      @(negedge clk); #1;
      chk("rmw_stall", {31'h0, stall_o}, 32'h0);
      chk("rmw_we", {31'h0, dmem_we_o}, 32'h1);
      chk("rmw_addr", dmem_addr_o, a & 32'hFFFFFFFC);
      chk("rmw_wdata", dmem_wdata_o, mw);
      @(posedge clk); #1;
      chk("rmw_wb_valid", {31'h0, wb_valid_o}, 32'h0);
      chk("rmw_err", {31'h0, err_o}, 32'h0);
    end
    valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        e, vl;
    logic [1:0]  c;
    logic [31:0] d;
    logic        rr, ww;
    logic [2:0]  f;
    logic [31:0] aa;
    int          k;

    for (int i = 0; i < 64; i++) preset(32'(i * 4), $urandom);
    preset(32'h10, 32'h11223344);
    preset(32'h20, 32'h80FF7F01);
    preset(32'h30, 32'hAABBCCDD);

    // A pending SW while in reset must not reach the memory.
    rst = 1'b1; valid_i = 1'b1; mem_read_i = 1'b0; mem_write_i = 1'b1;
    funct3_i = 3'b010; addr_i = 32'h10; wdata_i = 32'hFFFFFFFF; rd_i = 5'd3;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_we", {31'h0, dmem_we_o}, 32'h0);
    chk("rst_stall", {31'h0, stall_o}, 32'h0);
    chk("rst_addr", dmem_addr_o, 32'h0);
    chk("rst_wdata", dmem_wdata_o, 32'h0);
    chk("rst_regs", {wb_valid_o, wb_rd_o, err_o, err_cause_o}, 32'h0);
    chk("rst_wb_data", wb_data_o, 32'h0);
    @(negedge clk); rst = 1'b0; valid_i = 1'b0;

    vt[0]  = '{1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 2'b00, 1'b1, 32'h11223344};
    vt[1]  = '{1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 2'b00, 1'b0, 32'h0};
    vt[2]  = '{1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 2'b00, 1'b1, 32'hDEADBEEF};
    vt[3]  = '{1'b1, 1'b0, 3'b000, 32'h23, 32'h0,        1'b0, 2'b00, 1'b1, 32'hFFFFFF80};
    vt[4]  = '{1'b1, 1'b0, 3'b100, 32'h23, 32'h0,        1'b0, 2'b00, 1'b1, 32'h00000080};
    vt[5]  = '{1'b1, 1'b0, 3'b001, 32'h22, 32'h0,        1'b0, 2'b00, 1'b1, 32'hFFFF80FF};
    vt[6]  = '{1'b1, 1'b0, 3'b101, 32'h20, 32'h0,        1'b0, 2'b00, 1'b1, 32'h00007F01};
    vt[7]  = '{1'b0, 1'b1, 3'b000, 32'h31, 32'h12,       1'b0, 2'b00, 1'b0, 32'h0};
    vt[8]  = '{1'b1, 1'b0, 3'b010, 32'h30, 32'h0,        1'b0, 2'b00, 1'b1, 32'hAABB12DD};
    vt[9]  = '{1'b0, 1'b1, 3'b001, 32'h32, 32'h3456,     1'b0, 2'b00, 1'b0, 32'h0};
    vt[10] = '{1'b1, 1'b0, 3'b010, 32'h30, 32'h0,        1'b0, 2'b00, 1'b1, 32'h345612DD};
    vt[11] = '{1'b1, 1'b0, 3'b010, 32'h31, 32'h0,        1'b1, 2'b01, 1'b0, 32'h0};
    vt[12] = '{1'b1, 1'b1, 3'b010, 32'h10, 32'h0,        1'b1, 2'b10, 1'b0, 32'h0};
    vt[13] = '{1'b1, 1'b0, 3'b011, 32'h10, 32'h0,        1'b1, 2'b10, 1'b0, 32'h0};
    vt[14] = '{1'b0, 1'b1, 3'b100, 32'h30, 32'h0,        1'b1, 2'b10, 1'b0, 32'h0};
    vt[15] = '{1'b1, 1'b0, 3'b001, 32'h21, 32'h0,        1'b1, 2'b01, 1'b0, 32'h0};

    for (int i = 0; i < 16; i++) begin
      op(1'b1, vt[i].r, vt[i].w, vt[i].f3, vt[i].a, vt[i].wd, 5'(i + 1), e, c, vl, d);
      chk($sformatf("vec%0d_err", i), {31'h0, e}, {31'h0, vt[i].e_err});
      if (vt[i].e_err) chk($sformatf("vec%0d_cause", i), {30'h0, c}, {30'h0, vt[i].e_cause});
      chk($sformatf("vec%0d_valid", i), {31'h0, vl}, {31'h0, vt[i].e_valid});
      if (vt[i].e_valid) chk($sformatf("vec%0d_data", i), d, vt[i].e_data);
    end
    chk("mem_0x30", mem_w[12], 32'h345612DD);

    // Reset during the write cycle of an SB: write dropped, regs cleared.
    preset(32'h40, 32'h01020304);
    op(1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd7, e, c, vl, d);
    @(negedge clk);
    valid_i = 1'b1; mem_read_i = 1'b0; mem_write_i = 1'b1; funct3_i = 3'b000;
    addr_i = 32'h41; wdata_i = 32'h000000FF; rd_i = 5'd0;
    #1 chk("mr_stall", {31'h0, stall_o}, 32'h1);
    @(negedge clk); rst = 1'b1;
    #1 chk("mr_we", {31'h0, dmem_we_o}, 32'h0);
    @(posedge clk); #1;
    chk("mr_regs", {wb_valid_o, wb_rd_o, err_o, err_cause_o}, 32'h0);
    chk("mr_wb_data", wb_data_o, 32'h0);
    @(negedge clk); rst = 1'b0; valid_i = 1'b0;
    op(1'b1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd9, e, c, vl, d);
    chk("mr_word_kept", d, 32'h01020304);

    // Randomized traffic against the byte-level reference.
    for (int n = 0; n < 400; n++) begin
      k  = $urandom_range(0, 19);
      rr = (k < 9) || (k == 19);
      ww = (k >= 9);
      f  = (ww && !rr && $urandom_range(0, 4) != 0) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      aa = {24'h0, 8'($urandom_range(0, 255))};
      if ($urandom_range(0, 2) != 0) aa[1:0] = 2'b00;
      op((k != 18), rr, ww, f, aa, $urandom, 5'($urandom_range(0, 31)), e, c, vl, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the MEM stage of the RISC-V pipeline. It sits directly upstream of the word-only data memory. It converts byte, halfword and word loads/stores into word accesses and sign/zero-extends load data. Sub-word stores are done as a two-cycle read-modify-write, which stalls the pipeline for one cycle. Load results go out through a registered MEM/WB interface.

## Interface
- No parameters; data width is fixed at 32 bits and the register index at 5 bits.
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- valid_i  in  1  MEM-stage request valid
- mem_read_i  in  1  load request
- mem_write_i  in  1  store request
- funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- addr_i  in  32  byte address
- wdata_i  in  32  store data, right-aligned
- rd_i  in  5  load destination register
- stall_o  out  1  hold MEM and earlier stages this cycle
- dmem_addr_o  out  32  word-access address, bits [1:0] forced to 00
- dmem_wdata_o  out  32  full word to write
- dmem_we_o  out  1  word write enable, sampled by memory on rising edge
- dmem_rdata_i  in  32  combinational read of word at dmem_addr_o
- wb_valid_o  out  1  registered; load result valid
- wb_rd_o  out  5  registered destination register
- wb_data_o  out  32  registered extended load data
- err_o  out  1  registered one-cycle error pulse
- err_cause_o  out  2  registered; 01 misaligned, 10 illegal op

## Operation
- States are IDLE and RMW_WR.
- **IDLE, no request:** a request is `valid_i` with `mem_read_i` or `mem_write_i` set. With no request, `dmem_we_o` = 0, `stall_o` = 0 and `wb_valid_o` is 0 next cycle.
- **Illegal operations:** any of the following causes no memory access and raises `err_o` with cause 10 next cycle:
  - `mem_read_i` and `mem_write_i` both high;
  - a load with `funct3_i` of 011, 110 or 111;
  - a store with `funct3_i` not in {000, 001, 010}.
- **Misaligned access:** H/HU/SH with `addr_i[0]` = 1, or W/SW with `addr_i[1:0]` ≠ 00. There is no memory access; `err_o` is raised with cause 01 next cycle. Illegal takes priority over misaligned.
- **Load:**
  - Extract the byte/halfword from `dmem_rdata_i` at byte offset `addr_i[1:0]`.
  - Sign-extend for B/H; zero-extend for BU/HU.
  - Register the result into `wb_data_o`, `wb_rd_o` and `wb_valid_o` = 1.
  - No stall.
- **SW:** `dmem_wdata_o` = `wdata_i`, `dmem_we_o` = 1 in the same cycle; no stall.
- **SB/SH:**
  - In IDLE, drive `stall_o` = 1 and latch `dmem_rdata_i` merged with the low byte/halfword of `wdata_i` at the byte offset. Also latch the address. Go to RMW_WR.
  - In RMW_WR, drive `dmem_we_o` = 1 with the latched merged word and latched address, and `stall_o` = 0. Inputs are ignored. Return to IDLE.
  - The upstream holds its request during the stall cycle. The held request seen in RMW_WR is consumed, not re-executed.
- `wb_valid_o` is 0 after any cycle that did not complete a legal load. `err_o` is a single-cycle pulse.

## Timing
- **Reset:** state = IDLE. `wb_valid_o`, `wb_rd_o`, `wb_data_o`, `err_o` and `err_cause_o` are all 0. Combinational outputs are 0 while `rst` is high.
- **Reset during RMW_WR:** `dmem_we_o` is forced to 0 in that cycle and the write is dropped.
- **Latencies:**
  - Load: request cycle N, `wb_*` valid in N+1.
  - SW: memory updated at the end of cycle N.
  - SB/SH: memory updated at the end of cycle N+1; `stall_o` is high in N only.
- A load issued in the cycle after an RMW (N+2) reads the merged word.
- **Combinational path:** `dmem_addr_o` → `dmem_rdata_i` → extract/merge, within one cycle. `stall_o` is combinational from the state and inputs.

## Structure
- **Package `lsu_pkg`:**
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum: IDLE, RMW_WR;
  - error cause constants: ERR_MISALIGN = 01, ERR_ILLEGAL = 10.
- **Sub-module `lsu_align`:** purely combinational. Performs load extract/extend and store merge from (funct3, offset, word, wdata).

## Test plan
- **Word access:** mem[0x10] preset 0x11223344; LW addr 0x10 → `wb_data_o` = 0x11223344, `wb_valid_o` = 1 next cycle. Then SW 0xDEADBEEF to 0x10; a following LW returns 0xDEADBEEF.
- **Byte and halfword loads:** word 0x80FF7F01 at 0x20:
  - LB 0x23 → 0xFFFFFF80;
  - LBU 0x23 → 0x00000080;
  - LH 0x22 → 0xFFFF80FF;
  - LHU 0x20 → 0x00007F01.
- **Sub-word stores:** word 0xAABBCCDD at 0x30.
  - SB 0x12 to 0x31: `stall_o` high one cycle, word becomes 0xAABB12DD.
  - Then SH 0x3456 to 0x32: word becomes 0x345612DD.
- **Errors:**
  - LW at 0x31 → `err_o` pulse with cause 01, no write, `wb_valid_o` = 0.
  - `mem_read_i` and `mem_write_i` both high → cause 10.
  - Load with funct3 011 → cause 10.
- **Reset mid-RMW:** assert `rst` during RMW_WR of an SB → target word unchanged. All registered outputs are 0 and state is IDLE next cycle.
